// File: rtl/router_arb_pkg.sv
// ----------------------------------------------------------------------------
// router_arb_pkg
//   Definitions shared by the mesh-router output arbiter:
//     - NUM_PORTS / IDX_W    : port count and port-index width
//     - P_LOCAL..P_WEST      : symbolic input-port indices
//     - arb_state_t          : arbiter FSM state encoding
//     - onehot_to_idx()      : one-hot select vector to binary port index
// ----------------------------------------------------------------------------
package router_arb_pkg;

    localparam int NUM_PORTS = 5;
    localparam int IDX_W     = $clog2(NUM_PORTS);

    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_SOUTH = 3;
    localparam int P_WEST  = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // OR-reduction encoder: the result is only meaningful for one-hot or
    // all-zero inputs, and all-zero encodes to index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : router_arb_pkg

// File: rtl/router_rr_output_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational rotating-priority encoder.
//   Grants the first set bit of req scanning ptr, ptr+1, ..., NUM_PORTS-1,
//   0, ..., ptr-1.
// Ports
//   req  in  [NUM_PORTS-1:0]  request vector
//   ptr  in  [IDX_W-1:0]      highest-priority port
//   gnt  out [NUM_PORTS-1:0]  one-hot grant, zero when req is zero
//   idx  out [IDX_W-1:0]      binary index of gnt, zero when req is zero
// ----------------------------------------------------------------------------
module rr_pick
    import router_arb_pkg::*;
#(
    parameter int NUM_PORTS = router_arb_pkg::NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx
);

    localparam int DW = 2 * NUM_PORTS;

    logic [DW-1:0] dbl_req;
    logic [DW-1:0] below_ptr;
    logic [DW-1:0] masked;
    logic [DW-1:0] first;

    // Two copies of req side by side: masking the bits below ptr in the
    // lower copy leaves the upper copy to supply the wrapped-around ports,
    // so a plain lowest-set-bit search implements the rotation.
    always_comb begin
        dbl_req   = {req, req};
        below_ptr = (DW'(1) << ptr) - DW'(1);
        masked    = dbl_req & ~below_ptr;
        first     = masked & (~masked + DW'(1));
        gnt       = first[NUM_PORTS-1:0] | first[DW-1:NUM_PORTS];
        idx       = onehot_to_idx(gnt);
    end

endmodule : rr_pick

// File: rtl/router_rr_output_arbiter.sv
// ----------------------------------------------------------------------------
// router_rr_output_arbiter
//   Per-output-port round-robin arbiter for the 5-port mesh router. Picks one
//   requesting input per cycle, rotates priority after every completed
//   packet and holds the grant from head to tail so packets never interleave.
// Ports
//   CLK          in   clock, rising edge
//   RST_N        in   asynchronous reset, active low
//   req          in   [NUM_PORTS]  input i has a flit for this output
//   req_tail     in   [NUM_PORTS]  input i's presented flit is a tail
//   out_ready    in   downstream credit; flit moves when grant_valid && out_ready
//   grant        out  [NUM_PORTS]  one-hot crossbar select, zero when idle
//   grant_valid  out  |grant
//   grant_idx    out  [IDX_W]      binary index of grant, zero when no grant
//   locked       out  a multi-flit packet currently owns the output
// ----------------------------------------------------------------------------
module router_rr_output_arbiter
    import router_arb_pkg::*;
#(
    parameter int NUM_PORTS = router_arb_pkg::NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] req_tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 locked
);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] owner_oh;
    logic                 fire;
    logic                 tail_hit;

    // Priority moves one past the port whose packet just finished; the wrap
    // is a compare so NUM_PORTS need not be a power of two.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
        if (cur == IDX_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return cur + IDX_W'(1);
    endfunction

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign owner_oh = NUM_PORTS'(1) << owner_q;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        fire      = 1'b0;
        tail_hit  = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;

        case (state_q)
            ARB_IDLE: begin
                grant     = pick_gnt;
                grant_idx = pick_idx;
                fire      = (|grant) && out_ready;
                // grant is one-hot, so this selects the winner's tail bit
                tail_hit  = |(req_tail & grant);
                if (fire) begin
                    if (tail_hit) begin
                        ptr_d = next_ptr(pick_idx);
                    end else begin
                        state_d = ARB_LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                // Only the owner can be granted; if it bubbles the output
                // idles but the lock is kept.
                grant     = owner_oh & req;
                grant_idx = (|grant) ? owner_q : '0;
                fire      = (|grant) && out_ready;
                tail_hit  = |(req_tail & grant);
                if (fire && tail_hit) begin
                    state_d = ARB_IDLE;
                    ptr_d   = next_ptr(owner_q);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant_valid = |grant;
    assign locked      = (state_q == ARB_LOCKED);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    a_grant_onehot0 : assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0(grant));
    a_grant_has_req : assert property (@(posedge CLK) disable iff (!RST_N)
        grant_valid |-> req[grant_idx]);
    a_locked_owner  : assert property (@(posedge CLK) disable iff (!RST_N)
        (state_q == ARB_LOCKED) |-> ((grant == '0) || (grant == owner_oh)));

endmodule : router_rr_output_arbiter
